// File: rtl/rr_stream_mux.sv
// rr_stream_mux: registered N-to-1 valid/ready stream multiplexer.
// The grant comes either from a manual channel select or from a fair
// round-robin search that starts at rr_ptr. The winning word is captured in a
// single output register together with its channel tag. A saturating counter
// tracks how many input transfers have been accepted.
module rr_stream_mux #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         xfer_cnt
);

  // NUM_CH widened by one bit so it can be compared against a wrapped index sum.
  localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic [DATA_W-1:0] out_data_reg;
  logic [SEL_W-1:0]  out_ch_reg;
  logic              out_valid_reg;
  logic [SEL_W-1:0]  rr_ptr_reg;
  logic [CNT_W-1:0]  xfer_cnt_reg;

  logic              load_en;
  logic              grant;
  logic [SEL_W-1:0]  g;
  logic              rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W:0]    probe;

  // Valid vector padded to the full index range. Indices >= NUM_CH read as
  // not valid, so an out-of-range manual select can never win.
  logic [(1<<SEL_W)-1:0] valid_pad;

  // Zero-extend in_valid to every index that sel can address.
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_CH-1:0] = in_valid;
  end

  // Round-robin search. Walk downward so that the final write wins, which
  // leaves the smallest offset from rr_ptr. Wrap at NUM_CH, not at 2^SEL_W.
  always_comb begin
    rr_grant = 1'b0;
    rr_idx   = '0;
    probe    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      probe = {1'b0, rr_ptr_reg} + (SEL_W+1)'(k);
      if (probe >= NUM_CH_X) probe = probe - NUM_CH_X;
      if (valid_pad[probe[SEL_W-1:0]]) begin
        rr_grant = 1'b1;
        rr_idx   = probe[SEL_W-1:0];
      end
    end
  end

  // Pick the grant source for this cycle from the current mode.
  always_comb begin
    if (mode) begin
      grant = rr_grant;
      g     = rr_idx;
    end else begin
      grant = valid_pad[sel];
      g     = sel;
    end
  end

  // The output register may refill in the same cycle that it drains.
  assign load_en = ~out_valid_reg | out_ready;

  // One-hot ready towards the granted channel. Gating with rst_n keeps every
  // ready low while reset is held, even though the register then reads empty.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign in_ready[gi] = rst_n & load_en & grant & (g == SEL_W'(gi));
    end
  endgenerate

  // Output register, round-robin pointer and saturating transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      rr_ptr_reg    <= '0;
      xfer_cnt_reg  <= '0;
    end else if (load_en) begin
      if (grant) begin
        out_data_reg  <= in_data[g*DATA_W +: DATA_W];
        out_ch_reg    <= g;
        out_valid_reg <= 1'b1;
        rr_ptr_reg    <= (g == LAST_CH) ? '0 : g + 1'b1;
        if (xfer_cnt_reg != '1) xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign xfer_cnt  = xfer_cnt_reg;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux. Instance a uses 8 channels and a 16-bit
// counter. Instance b uses 5 channels and a 4-bit counter, which exercises the
// non-power-of-2 wrap, out-of-range selects and counter saturation. Both
// instances share the same stimulus.
module tb_rr_stream_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_valid = '0;
  logic        mode = 1'b0;
  logic [2:0]  sel = '0;
  logic        out_ready = 1'b0;

  logic [7:0]  in_ready_a;
  logic [7:0]  out_data_a;
  logic [2:0]  out_ch_a;
  logic        out_valid_a;
  logic [15:0] xfer_cnt_a;

  logic [4:0]  in_ready_b;
  logic [7:0]  out_data_b;
  logic [2:0]  out_ch_b;
  logic        out_valid_b;
  logic [3:0]  xfer_cnt_b;

  int checks = 0;
  int errors = 0;

  // Expected output words, packed as channel*256 + data.
  int qa[$];
  int qb[$];

  // Reference state: output occupied, next round-robin start, accept count.
  bit mv[2];
  int mptr[2];
  int mcnt[2];

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(8), .DATA_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .mode(mode), .sel(sel), .out_data(out_data_a),
    .out_ch(out_ch_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt_a)
  );

  rr_stream_mux #(.NUM_CH(5), .DATA_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[39:0]), .in_valid(in_valid[4:0]),
    .in_ready(in_ready_b), .mode(mode), .sel(sel), .out_data(out_data_b),
    .out_ch(out_ch_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference grant rule: manual uses sel if it is in range and valid.
  // Round-robin returns the first valid channel at or after ptr, wrapping.
  function automatic int mgrant(input int nch, input logic m, input int s,
                                input logic [7:0] v, input int ptr);
    int c;
    if (!m) return (s < nch && v[s]) ? s : -1;
    for (int k = 0; k < nch; k++) begin
      c = (ptr + k) % nch;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Check one instance against the reference for this cycle, then advance the
  // reference to the state expected after the coming rising edge.
  task automatic step(input int d, input int nch, input int maxc,
                      input int act_valid, input int act_cnt, input int act_rdy);
    int g;
    int exp_rdy;
    int entry;
    bit load;
    string tag;
    tag = (d == 0) ? "a" : "b";
    chk({tag, "_out_valid"}, act_valid, int'(mv[d]));
    chk({tag, "_xfer_cnt"}, act_cnt, mcnt[d]);
    load = !mv[d] || out_ready;
    g = mgrant(nch, mode, int'(sel), in_valid, mptr[d]);
    exp_rdy = (load && g >= 0) ? (1 << g) : 0;
    chk({tag, "_in_ready"}, act_rdy, exp_rdy);
    if (load && g >= 0) begin
      entry = g * 256 + int'(in_data[g*8 +: 8]);
      if (d == 0) qa.push_back(entry);
      else qb.push_back(entry);
      mv[d] = 1'b1;
      mptr[d] = (g + 1) % nch;
      if (mcnt[d] < maxc) mcnt[d]++;
    end else if (load) begin
      mv[d] = 1'b0;
    end
  endtask

  // Predictor: runs on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mv[d] = 1'b0;
        mptr[d] = 0;
        mcnt[d] = 0;
      end
      qa.delete();
      qb.delete();
      chk("rst_in_ready_a", int'(in_ready_a), 0);
      chk("rst_in_ready_b", int'(in_ready_b), 0);
    end else begin
      step(0, 8, 65535, int'(out_valid_a), int'(xfer_cnt_a), int'(in_ready_a));
      step(1, 5, 15, int'(out_valid_b), int'(xfer_cnt_b), int'(in_ready_b));
    end
  end

  // Monitor: compare each word the consumer takes with the scoreboard head.
  always @(negedge clk) begin
    int e;
    if (rst_n && out_ready) begin
      if (out_valid_a) begin
        if (qa.size() == 0) chk("a_unexpected_word", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_out_data", int'(out_data_a), e % 256);
          chk("a_out_ch", int'(out_ch_a), e / 256);
        end
      end
      if (out_valid_b) begin
        if (qb.size() == 0) chk("b_unexpected_word", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_out_data", int'(out_data_b), e % 256);
          chk("b_out_ch", int'(out_ch_b), e / 256);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid_a", int'(out_valid_a), 0);
    chk("rst_out_data_a", int'(out_data_a), 0);
    chk("rst_out_ch_a", int'(out_ch_a), 0);
    chk("rst_xfer_cnt_a", int'(xfer_cnt_a), 0);
    chk("rst_out_valid_b", int'(out_valid_b), 0);
    chk("rst_xfer_cnt_b", int'(xfer_cnt_b), 0);
    chk("rst_in_ready_now", int'(in_ready_a), 0);
  endtask

  // Assert reset between edges and check that the outputs clear immediately.
  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
  endtask

  initial begin
    // Reset, and start the all-valid round-robin rotation.
    set_ramp();
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 8'hFF;
    #2 check_reset_values();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (9) tick();

    // Reset mid-stream, then resume the rotation from channel 0.
    async_reset();
    repeat (4) tick();

    // Sparse round-robin: a manual accept of channel 2 leaves rr_ptr at 3.
    async_reset();
    mode = 1'b0; sel = 3'd2; in_valid = 8'h04;
    tick();
    mode = 1'b1; in_valid = 8'h44;
    repeat (5) tick();

    // Manual select of channel 5 while channel 1 also requests.
    mode = 1'b0; sel = 3'd5; in_data[5*8 +: 8] = 8'h3C; in_valid = 8'h22;
    repeat (3) tick();
    in_valid = 8'h02;
    repeat (3) tick();

    // Backpressure for four cycles, then release.
    set_ramp();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Randomised traffic with a reset in the middle.
    for (int n = 0; n < 400; n++) begin
      in_data = {$urandom, $urandom};
      in_valid = 8'($urandom) & 8'($urandom | $urandom);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (n == 200) async_reset();
      else tick();
    end

    // Drain everything and confirm nothing expected is left over.
    in_valid = '0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    chk("b_cnt_saturated", int'(xfer_cnt_b), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
